// File: rtl/axi_burst_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_mem
// Brief    : AXI-style word-addressed burst memory slave with independent
//            read/write FSMs, FIXED/INCR/WRAP bursts, WSTRB and SLVERR.
// Revision : 1.0  initial release
// ============================================================================
module axi_burst_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    W_EN,
    input  logic                    R_EN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [1:0]              ARBURST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST
);

    localparam int                  c_NB          = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] c_DEPTH       = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [1:0]          c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]          c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]          c_W_IDLE      = 2'd0;
    localparam logic [1:0]          c_W_DATA      = 2'd1;
    localparam logic [1:0]          c_W_RESP      = 2'd2;
    localparam logic                c_R_IDLE      = 1'b0;
    localparam logic                c_R_DATA      = 1'b1;

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                          input logic [7:0] len,
                                                          input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        mask = ADDR_WIDTH'(len);
        inc  = addr + ADDR_WIDTH'(1);
        case (burst)
            2'b01:   f_next_addr = inc;
            2'b10:   f_next_addr = (addr & ~mask) | (inc & mask);
            default: f_next_addr = addr;
        endcase
    endfunction

    function automatic logic f_illegal(input logic [7:0] len, input logic [1:0] burst);
        f_illegal = (burst == 2'b11) ||
                    ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                           (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        f_in_range = ({1'b0, addr} < c_DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Write channel state
    logic [1:0]            r_w_state, w_w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_w_addr,  w_w_addr_nxt;
    logic [7:0]            r_w_len,   w_w_len_nxt;
    logic [1:0]            r_w_burst, w_w_burst_nxt;
    logic [7:0]            r_w_beat,  w_w_beat_nxt;
    logic                  r_w_err,   w_w_err_nxt;
    logic                  r_w_ill,   w_w_ill_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready,  w_wready_nxt;
    logic                  r_bvalid,  w_bvalid_nxt;
    logic [1:0]            r_bresp,   w_bresp_nxt;
    logic                  w_mem_we;

    // Read channel state; r_r_addr is the address of the next beat to load
    logic                  r_r_state, w_r_state_nxt;
    logic [ADDR_WIDTH-1:0] r_r_addr,  w_r_addr_nxt;
    logic [7:0]            r_r_len,   w_r_len_nxt;
    logic [1:0]            r_r_burst, w_r_burst_nxt;
    logic [7:0]            r_r_beat,  w_r_beat_nxt;
    logic                  r_r_ill,   w_r_ill_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid,  w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;
    logic [1:0]            r_rresp,   w_rresp_nxt;
    logic                  r_rlast,   w_rlast_nxt;
    logic                  w_load;
    logic                  w_ld_ok;
    logic [ADDR_WIDTH-1:0] w_ld_addr;
    logic                  w_ld_ill;

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_w_addr_nxt  = r_w_addr;
        w_w_len_nxt   = r_w_len;
        w_w_burst_nxt = r_w_burst;
        w_w_beat_nxt  = r_w_beat;
        w_w_err_nxt   = r_w_err;
        w_w_ill_nxt   = r_w_ill;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_mem_we      = 1'b0;
        case (r_w_state)
            c_W_IDLE: begin
                w_awready_nxt = W_EN;
                if (AWVALID && r_awready) begin
                    w_w_state_nxt = c_W_DATA;
                    w_w_addr_nxt  = AWADDR;
                    w_w_len_nxt   = AWLEN;
                    w_w_burst_nxt = AWBURST;
                    w_w_beat_nxt  = 8'd0;
                    w_w_ill_nxt   = f_illegal(AWLEN, AWBURST);
                    w_w_err_nxt   = w_w_ill_nxt;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                end
            end
            c_W_DATA: begin
                if (WVALID && r_wready) begin
                    w_mem_we     = !r_w_ill && f_in_range(r_w_addr);
                    w_w_err_nxt  = r_w_err || r_w_ill || !f_in_range(r_w_addr) ||
                                   (WLAST != (r_w_beat == r_w_len));
                    w_w_addr_nxt = f_next_addr(r_w_addr, r_w_len, r_w_burst);
                    w_w_beat_nxt = r_w_beat + 8'd1;
                    // Burst length is authoritative; WLAST only feeds the error flag
                    if (r_w_beat == r_w_len) begin
                        w_w_state_nxt = c_W_RESP;
                        w_wready_nxt  = 1'b0;
                        w_bvalid_nxt  = 1'b1;
                        w_bresp_nxt   = w_w_err_nxt ? c_RESP_SLVERR : c_RESP_OKAY;
                    end
                end
            end
            c_W_RESP: begin
                if (BREADY) begin
                    w_w_state_nxt = c_W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_bresp_nxt   = c_RESP_OKAY;
                    w_awready_nxt = W_EN;
                end
            end
            default: w_w_state_nxt = c_W_IDLE;
        endcase
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        w_r_addr_nxt  = r_r_addr;
        w_r_len_nxt   = r_r_len;
        w_r_burst_nxt = r_r_burst;
        w_r_beat_nxt  = r_r_beat;
        w_r_ill_nxt   = r_r_ill;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        w_rlast_nxt   = r_rlast;
        w_load        = 1'b0;
        w_ld_addr     = r_r_addr;
        w_ld_ill      = r_r_ill;
        case (r_r_state)
            c_R_IDLE: begin
                w_arready_nxt = R_EN;
                if (ARVALID && r_arready) begin
                    w_r_state_nxt = c_R_DATA;
                    w_r_len_nxt   = ARLEN;
                    w_r_burst_nxt = ARBURST;
                    w_r_ill_nxt   = f_illegal(ARLEN, ARBURST);
                    w_r_beat_nxt  = 8'd0;
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rlast_nxt   = (ARLEN == 8'd0);
                    w_r_addr_nxt  = f_next_addr(ARADDR, ARLEN, ARBURST);
                    w_load        = 1'b1;
                    w_ld_addr     = ARADDR;
                    w_ld_ill      = w_r_ill_nxt;
                end
            end
            default: begin
                if (RREADY) begin
                    if (r_rlast) begin
                        w_r_state_nxt = c_R_IDLE;
                        w_rvalid_nxt  = 1'b0;
                        w_rlast_nxt   = 1'b0;
                        w_rresp_nxt   = c_RESP_OKAY;
                        w_rdata_nxt   = '0;
                        w_arready_nxt = R_EN;
                    end else begin
                        w_r_beat_nxt = r_r_beat + 8'd1;
                        w_rlast_nxt  = (w_r_beat_nxt == r_r_len);
                        w_r_addr_nxt = f_next_addr(r_r_addr, r_r_len, r_r_burst);
                        w_load       = 1'b1;
                    end
                end
            end
        endcase
        // Memory is sampled before this edge's write lands, so same-word reads see old data
        w_ld_ok = !w_ld_ill && f_in_range(w_ld_addr);
        if (w_load) begin
            w_rdata_nxt = w_ld_ok ? r_mem[w_ld_addr] : '0;
            w_rresp_nxt = w_ld_ok ? c_RESP_OKAY : c_RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_w_state <= c_W_IDLE;
            r_w_addr  <= '0;
            r_w_len   <= 8'd0;
            r_w_burst <= 2'b00;
            r_w_beat  <= 8'd0;
            r_w_err   <= 1'b0;
            r_w_ill   <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_r_state <= c_R_IDLE;
            r_r_addr  <= '0;
            r_r_len   <= 8'd0;
            r_r_burst <= 2'b00;
            r_r_beat  <= 8'd0;
            r_r_ill   <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_w_addr  <= w_w_addr_nxt;
            r_w_len   <= w_w_len_nxt;
            r_w_burst <= w_w_burst_nxt;
            r_w_beat  <= w_w_beat_nxt;
            r_w_err   <= w_w_err_nxt;
            r_w_ill   <= w_w_ill_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_r_state <= w_r_state_nxt;
            r_r_addr  <= w_r_addr_nxt;
            r_r_len   <= w_r_len_nxt;
            r_r_burst <= w_r_burst_nxt;
            r_r_beat  <= w_r_beat_nxt;
            r_r_ill   <= w_r_ill_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rlast   <= w_rlast_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_mem_we) begin
            for (int b = 0; b < c_NB; b++) begin
                if (WSTRB[b]) r_mem[r_w_addr][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;

endmodule
`default_nettype wire

// File: doc/axi_burst_mem.md
Name: axi_burst_mem

Overview:
Parametrised AXI-style word-addressed memory slave, successor to axi_memory. Adds read bursts (ARLEN/ARBURST), FIXED/INCR/WRAP burst modes on both channels, WSTRB byte-lane writes, RLAST, and SLVERR reporting for out-of-range or illegal bursts. Read and write channels run independent FSMs, so a read burst can overlap a write burst. Serves as the shared data memory behind accelerator masters.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8.
ADDR_WIDTH, 5, word-address width.
MEM_DEPTH, 32, number of words; must be <= 2**ADDR_WIDTH.

Ports:
ACLK  in  1  clock, rising edge.
ARESETn  in  1  asynchronous active-low reset.
W_EN / R_EN  in  1 each  gate acceptance of new write / read bursts.
AWVALID/AWREADY  in/out  1  write-address handshake.
AWADDR  in  ADDR_WIDTH  start word address.
AWLEN  in  8  beats-1.
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
WVALID/WREADY  in/out  1  write-data handshake.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte-lane enables.
WLAST  in  1  last write beat.
BVALID/BREADY  out/in  1  write-response handshake.
BRESP  out  2  00 OKAY, 10 SLVERR.
ARVALID/ARREADY  in/out  1  read-address handshake.
ARADDR  in  ADDR_WIDTH  start word address.
ARLEN  in  8  beats-1.
ARBURST  in  2  same encoding as AWBURST.
RVALID/RREADY  out/in  1  read-data handshake.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  per-beat response.
RLAST  out  1  last read beat.

Behaviour:
- Reset (ARESETn=0, async): all outputs 0; both FSMs go to IDLE; all memory words cleared to 0. Asserting reset mid-burst abandons the burst with no response. AWREADY/ARREADY are first asserted on the first rising edge after release, provided W_EN/R_EN are high.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY = W_EN. On AWVALID&&AWREADY, latch addr/len/burst, clear beat count and error flag, and go to W_DATA. AWREADY drops on that edge.
  - W_DATA: WREADY=1. Each WVALID&&WREADY writes the byte lanes selected by WSTRB (other lanes keep their value) and advances the address.
  - The burst ends on the beat count (len+1 beats), not on WLAST. A mismatch between WLAST and (beat==len) on any beat sets the error flag.
  - W_RESP: BVALID=1, BRESP=SLVERR if the error flag is set, else OKAY. BVALID is held until BREADY, then the FSM returns to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY = R_EN. On the AR handshake, the first beat's RDATA/RRESP/RLAST are registered and RVALID=1 on the next cycle (latency 1).
  - R_DATA: outputs stay stable while RVALID && !RREADY. On handshake, the next beat is loaded on the same edge, so there are no bubbles.
  - After the RLAST handshake: RVALID=0, return to R_IDLE, ARREADY is high the following cycle.
- Address generation (ADDR_WIDTH bits):
  - FIXED: address constant.
  - INCR: addr+1, wrapping modulo 2**ADDR_WIDTH.
  - WRAP: mask=len; next = (addr & ~mask) | ((addr+1) & mask).
- Errors:
  - Illegal burst: BURST=11, or WRAP with len+1 not in {2,4,8,16}. Every beat gets SLVERR, no memory update, RDATA=0.
  - Out-of-range beat (addr >= MEM_DEPTH): write ignored, RDATA=0, SLVERR for that beat / the burst BRESP.
  - Other beats return OKAY.
- Simultaneous events:
  - A read beat loaded on the same edge as a write to the same word returns the old value.
  - AW and AR handshakes may occur in the same cycle.
  - Deasserting W_EN/R_EN mid-burst does not stop a burst already in progress.

Test Plan:
- Write INCR AWADDR=5, AWLEN=3, WDATA=i*i, WSTRB=F, then read INCR ARADDR=5, ARLEN=3 -> RDATA 0,1,4,9; RLAST on beat 3 only; BRESP=00; RRESP=00.
- WRAP write AWADDR=6, AWLEN=3 -> beats land at 6,7,4,5. Read WRAP ARADDR=6, ARLEN=3 -> same order. WRAP with AWLEN=2 -> BRESP=10 and memory unchanged.
- Partial write WSTRB=4'b0101, WDATA=AABBCCDD over word 0x11223344 -> read 0x11BB33DD. FIXED write of 3 beats to addr 2 -> last beat's data stored.
- MEM_DEPTH=24, INCR read ARADDR=22, ARLEN=3 -> beats 0-1 OKAY with data; beats 2-3 RRESP=10, RDATA=0.
- RREADY toggled 1-0-0-1 during a 4-beat read -> RDATA held while stalled, no beat lost or duplicated. WLAST asserted on beat 1 of 4 -> all 4 beats written, BRESP=10.
- Reset pulsed mid write burst -> all outputs 0 immediately; memory reads back 0; AWREADY=1 one edge after release; a new burst completes normally.
